// File: rtl/ttt_score_digits.sv
// ttt_score_digits: Tic-Tac-Toe match tally (X/O/draw, two-digit saturating BCD) with post-result flash/blink
module ttt_score_digits #(
  parameter int FLASH_CYCLES = 50_000_000,
  parameter int BLINK_HALF   = 12_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       game_over_valid,
  input  logic [1:0] winner,
  input  logic       clear_scores,
  output logic [3:0] x_tens,
  output logic [3:0] x_ones,
  output logic [3:0] o_tens,
  output logic [3:0] o_ones,
  output logic [3:0] d_tens,
  output logic [3:0] d_ones,
  output logic [2:0] blank,
  output logic       busy
);
  localparam int FW = $clog2(FLASH_CYCLES);
  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam logic [FW-1:0] F_LAST = FW'(FLASH_CYCLES - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_HALF - 1);
  typedef enum logic {IDLE, FLASH} state_t;
  state_t state_q, state_d;
  logic [7:0] x_q, x_d, o_q, o_d, d_q, d_d;
  logic [1:0] sel_q, sel_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic phase_q, phase_d;
  logic [2:0] blank_q, blank_d;
  logic accept;
  // Two-digit BCD increment that sticks at 99
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return v == 8'h99 ? v : v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction
  assign accept = state_q == IDLE && game_over_valid && winner != 2'b00;
  // Next-state: clear dominates, IDLE accepts a result, FLASH runs the flash and blink timers
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    o_d = o_q;
    d_d = d_q;
    sel_d = sel_q;
    fcnt_d = fcnt_q;
    bcnt_d = bcnt_q;
    phase_d = phase_q;
    if (clear_scores) begin
      state_d = IDLE;
      x_d = '0;
      o_d = '0;
      d_d = '0;
      sel_d = '0;
      fcnt_d = '0;
      bcnt_d = '0;
      phase_d = 1'b0;
    end else if (accept) begin
      x_d = winner == 2'b01 ? bcd_inc(x_q) : x_q;
      o_d = winner == 2'b10 ? bcd_inc(o_q) : o_q;
      d_d = winner == 2'b11 ? bcd_inc(d_q) : d_q;
      sel_d = winner - 2'd1;
      fcnt_d = '0;
      bcnt_d = '0;
      phase_d = 1'b0;
      state_d = FLASH;
    end else if (state_q == FLASH) begin
      bcnt_d = bcnt_q == B_LAST ? '0 : bcnt_q + 1'b1;
      phase_d = bcnt_q == B_LAST ? ~phase_q : phase_q;
      fcnt_d = fcnt_q == F_LAST ? '0 : fcnt_q + 1'b1;
      state_d = fcnt_q == F_LAST ? IDLE : FLASH;
    end
    blank_d = state_d == FLASH ? 3'(phase_d) << sel_d : 3'b000;
  end
  // State register; reset behaves exactly like clear_scores
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      x_q <= '0;
      o_q <= '0;
      d_q <= '0;
      sel_q <= '0;
      fcnt_q <= '0;
      bcnt_q <= '0;
      phase_q <= 1'b0;
      blank_q <= 3'b000;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      o_q <= o_d;
      d_q <= d_d;
      sel_q <= sel_d;
      fcnt_q <= fcnt_d;
      bcnt_q <= bcnt_d;
      phase_q <= phase_d;
      blank_q <= blank_d;
    end
  end
  assign {x_tens, x_ones} = x_q;
  assign {o_tens, o_ones} = o_q;
  assign {d_tens, d_ones} = d_q;
  assign blank = blank_q;
  assign busy = state_q == FLASH;
endmodule

// File: tb/tb_ttt_score_digits.sv
// tb_ttt_score_digits: directed bench with a count-based score/flash model checked every cycle
module tb_ttt_score_digits;
  localparam int FC = 8;
  localparam int BH = 2;
  logic clk = 0, reset = 1, game_over_valid = 0, clear_scores = 0;
  logic [1:0] winner = 0;
  logic [3:0] x_tens, x_ones, o_tens, o_ones, d_tens, d_ones;
  logic [2:0] blank;
  logic busy;
  int total = 0, passed = 0;
  bit chk_en = 0;
  int mx = 0, mo = 0, md = 0, k = 0, msel = 0;
  bit mbusy = 0;
  logic [2:0] eb;
  logic [7:0] pat;

  ttt_score_digits #(.FLASH_CYCLES(FC), .BLINK_HALF(BH)) dut (
    .clk(clk), .reset(reset), .game_over_valid(game_over_valid), .winner(winner),
    .clear_scores(clear_scores), .x_tens(x_tens), .x_ones(x_ones), .o_tens(o_tens),
    .o_ones(o_ones), .d_tens(d_tens), .d_ones(d_ones), .blank(blank), .busy(busy));

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: scores as plain integers, flash as a cycle index k since acceptance
  always @(posedge clk) begin
    if (reset || clear_scores) begin
      mx = 0; mo = 0; md = 0; mbusy = 0; k = 0;
    end else if (!mbusy) begin
      if (game_over_valid && winner != 0) begin
        if (winner == 1) mx = mx < 99 ? mx + 1 : 99;
        if (winner == 2) mo = mo < 99 ? mo + 1 : 99;
        if (winner == 3) md = md < 99 ? md + 1 : 99;
        msel = int'(winner) - 1;
        mbusy = 1;
        k = 0;
      end
    end else begin
      k++;
      if (k == FC) mbusy = 0;
    end
  end

  always @(negedge clk) if (chk_en) begin
    eb = 3'b000;
    if (mbusy) eb[msel] = ((k / BH) % 2) != 0;
    check("x_tens", x_tens, mx / 10);
    check("x_ones", x_ones, mx % 10);
    check("o_tens", o_tens, mo / 10);
    check("o_ones", o_ones, mo % 10);
    check("d_tens", d_tens, md / 10);
    check("d_ones", d_ones, md % 10);
    check("blank", blank, eb);
    check("busy", busy, mbusy);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse(input logic [1:0] w);
    game_over_valid = 1;
    winner = w;
    tick();
    game_over_valid = 0;
    winner = 0;
  endtask

  task automatic clr();
    clear_scores = 1;
    tick();
    clear_scores = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      total++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles", n);
    end
    #1;
  endtask

  initial begin
    tick();
    tick();
    reset = 0;
    chk_en = 1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_blank", blank, 0);
    check("rst_x", {x_tens, x_ones}, 0);
    // 1: single X result and blink pattern
    pulse(2'b01);
    pat = 8'b1100_1100;
    for (int i = 0; i < FC; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check("t1_x_ones", x_ones, 1);
        check("t1_busy", busy, 1);
      end
      check("t1_blank0", blank, {2'b00, pat[i]});
    end
    @(negedge clk);
    check("t1_end_busy", busy, 0);
    check("t1_end_blank", blank, 0);
    // 2: eleven X wins, ones wraps at the tenth
    clr();
    for (int i = 1; i <= 11; i++) begin
      pulse(2'b01);
      wait_idle();
      if (i == 10) check("t2_x10", {x_tens, x_ones}, 8'h10);
    end
    check("t2_x11", {x_tens, x_ones}, 8'h11);
    check("t2_o", {o_tens, o_ones}, 0);
    check("t2_d", {d_tens, d_ones}, 0);
    // 3: draws saturate at 99 but still flash
    clr();
    for (int i = 0; i < 99; i++) begin
      pulse(2'b11);
      wait_idle();
    end
    check("t3_d99", {d_tens, d_ones}, 8'h99);
    pulse(2'b11);
    @(negedge clk);
    check("t3_d_hold", {d_tens, d_ones}, 8'h99);
    check("t3_busy", busy, 1);
    @(negedge clk);
    @(negedge clk);
    check("t3_blank2", blank, 3'b100);
    wait_idle();
    // 4: X result during O flash is dropped
    clr();
    pulse(2'b10);
    tick();
    tick();
    pulse(2'b01);
    wait_idle();
    check("t4_o", {o_tens, o_ones}, 8'h01);
    check("t4_x", {x_tens, x_ones}, 0);
    @(negedge clk);
    check("t4_no_reentry", busy, 0);
    // 5: winner=00 ignored
    pulse(2'b00);
    @(negedge clk);
    check("t5_busy", busy, 0);
    check("t5_o", {o_tens, o_ones}, 8'h01);
    // 6: clear beats simultaneous X pulse, and aborts FLASH
    #1;
    clear_scores = 1;
    game_over_valid = 1;
    winner = 2'b01;
    tick();
    clear_scores = 0;
    game_over_valid = 0;
    winner = 0;
    @(negedge clk);
    check("t6_x", {x_tens, x_ones}, 0);
    check("t6_o", {o_tens, o_ones}, 0);
    check("t6_busy", busy, 0);
    #1;
    pulse(2'b10);
    tick();
    tick();
    clr();
    @(negedge clk);
    check("t6_abort_busy", busy, 0);
    check("t6_abort_blank", blank, 0);
    check("t6_abort_o", {o_tens, o_ones}, 0);
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
